// File: rtl/led_matrix_scan_decoder.sv
// Rebuilds one column-scanned 5x7 LED frame and matches it against the glyph set.
// Ports: clk, rstn (async, active-high reset); col[4:0], lin[6:0] scan lines in;
//        sym[2:0], sym_valid, match, frame[34:0], seq_err, busy out.
module led_matrix_scan_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 2,
   parameter int TIMEOUT       = 1024
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  col,
   input  logic [6:0]  lin,
   output logic [2:0]  sym,
   output logic        sym_valid,
   output logic        match,
   output logic [34:0] frame,
   output logic        seq_err,
   output logic        busy
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [34:0] G_LOW  = {5{7'h3F}};
   localparam logic [34:0] G_MED  = {5{7'h37}};
   localparam logic [34:0] G_HIGH = {5{7'h36}};
   localparam logic [34:0] G_ERR  =
      {7'h3E, 7'h36, 7'h36, 7'h36, 7'h00};
   localparam logic [34:0] G_A    =
      {7'h00, 7'h6E, 7'h6E, 7'h6E, 7'h00};
   localparam logic [34:0] G_G    =
      {7'h06, 7'h36, 7'h3E, 7'h3E, 7'h00};
   localparam logic [34:0] G_ZERO =
      {7'h00, 7'h3E, 7'h3E, 7'h3E, 7'h00};

   typedef enum logic [1:0] {
      S_HUNT,
      S_CAPT,
      S_DEC
   } state_t;

   state_t r_state;
   state_t w_state_n;

   logic [4:0]    r_col_sync [SYNC_STAGES];
   logic [6:0]    r_lin_sync [SYNC_STAGES];
   logic [4:0]    w_col_s;
   logic [6:0]    w_lin_s;
   logic [4:0]    w_col_n;
   logic [6:0]    w_lin_n;
   logic [4:0]    w_cap_col;
   logic [6:0]    w_rows;

   logic [SW-1:0] r_stab;
   logic [SW-1:0] w_stab_n;
   logic          r_done;
   logic          w_chg;
   logic          w_evt;
   logic          w_cap;
   logic          w_multi;
   logic [2:0]    w_idx;

   logic [6:0]    r_buf [5];
   logic [34:0]   w_buf;
   logic [2:0]    r_exp;
   logic [2:0]    w_exp_n;
   logic [TW-1:0] r_tmo;
   logic          w_tmo_hit;
   logic          w_tmo_clr;
   logic          w_wr;
   logic          w_err_n;
   logic          w_valid_n;
   logic          w_decode;

   logic [2:0]    w_sym;
   logic          w_match;
   logic [2:0]    r_sym;
   logic          r_match;
   logic [34:0]   r_frame;
   logic          r_valid;
   logic          r_err;

   // input synchronizers
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_col_sync[i] <= '0;
            r_lin_sync[i] <= '0;
         end
      end else begin
         r_col_sync[0] <= col;
         r_lin_sync[0] <= lin;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_col_sync[i] <= r_col_sync[i-1];
            r_lin_sync[i] <= r_lin_sync[i-1];
         end
      end
   end

   assign w_col_s = r_col_sync[SYNC_STAGES-1];
   assign w_lin_s = r_lin_sync[SYNC_STAGES-1];

   // w_*_n is the value the synced bus takes on this edge; the edge
   // that loads a new value counts as its first stable edge
   generate
      if (SYNC_STAGES == 1) begin : g_tap1
         assign w_col_n = col;
         assign w_lin_n = lin;
      end else begin : g_tapn
         assign w_col_n = r_col_sync[SYNC_STAGES-2];
         assign w_lin_n = r_lin_sync[SYNC_STAGES-2];
      end
   endgenerate

   // with a single stable edge the capture happens as the value lands,
   // otherwise the held synced value is used
   assign w_cap_col = (STABLE_CYCLES > 1) ? w_col_s : w_col_n;
   assign w_rows    = (STABLE_CYCLES > 1) ? w_lin_s : w_lin_n;

   assign w_chg = (w_col_n != w_col_s);

   always_comb begin
      w_stab_n = r_stab + 1'b1;
      if (w_chg)
         w_stab_n = SW'(1);
      else if (r_stab == STAB_MAX)
         w_stab_n = STAB_MAX;
   end

   // r_done blocks a second event for the same column occurrence
   assign w_evt   = (w_stab_n == STAB_MAX) && (w_chg || !r_done);
   assign w_cap   = w_evt && $onehot(w_cap_col);
   assign w_multi = w_evt && ($countones(w_cap_col) > 1);

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_stab <= '0;
         r_done <= 1'b0;
      end else begin
         r_stab <= w_stab_n;
         r_done <= (r_done && !w_chg) || w_evt;
      end
   end

   always_comb begin
      w_idx = 3'd0;
      case (w_cap_col)
         5'b00010: w_idx = 3'd1;
         5'b00100: w_idx = 3'd2;
         5'b01000: w_idx = 3'd3;
         5'b10000: w_idx = 3'd4;
         default:  w_idx = 3'd0;
      endcase
   end

   assign w_buf = {r_buf[4], r_buf[3], r_buf[2],
                   r_buf[1], r_buf[0]};

   assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo == TMO_LAST);

   // state register
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)
         r_state <= S_HUNT;
      else
         r_state <= w_state_n;
   end

   // next state
   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         S_HUNT: begin
            if (w_cap && w_idx == 3'd0)
               w_state_n = S_CAPT;
         end
         S_CAPT: begin
            if (w_cap) begin
               if (w_idx == r_exp)
                  w_state_n = (w_idx == 3'd4) ? S_DEC : S_CAPT;
               else if (w_idx == 3'd0)
                  w_state_n = S_CAPT;
               else
                  w_state_n = S_HUNT;
            end else if (w_tmo_hit) begin
               w_state_n = S_HUNT;
            end
         end
         S_DEC: begin
            // a col_1 landing on the decode edge opens the next frame
            w_state_n = (w_cap && w_idx == 3'd0) ? S_CAPT : S_HUNT;
         end
         default: w_state_n = S_HUNT;
      endcase
      if (w_multi)
         w_state_n = S_HUNT;
   end

   // outputs / datapath controls
   always_comb begin
      w_err_n   = w_multi;
      w_valid_n = 1'b0;
      w_decode  = 1'b0;
      w_wr      = 1'b0;
      w_tmo_clr = 1'b0;
      w_exp_n   = r_exp;
      busy      = (r_state != S_HUNT);
      unique case (r_state)
         S_HUNT, S_DEC: begin
            if (r_state == S_DEC && !w_multi) begin
               w_valid_n = 1'b1;
               w_decode  = 1'b1;
            end
            if (w_cap && w_idx == 3'd0) begin
               w_wr      = 1'b1;
               w_tmo_clr = 1'b1;
               w_exp_n   = 3'd1;
            end
         end
         S_CAPT: begin
            if (w_cap) begin
               w_tmo_clr = 1'b1;
               if (w_idx == r_exp) begin
                  w_wr    = 1'b1;
                  w_exp_n = r_exp + 3'd1;
               end else begin
                  w_err_n = 1'b1;
                  if (w_idx == 3'd0) begin
                     w_wr    = 1'b1;
                     w_exp_n = 3'd1;
                  end
               end
            end else if (w_tmo_hit) begin
               w_err_n = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // glyph match
   always_comb begin
      w_sym   = 3'd0;
      w_match = 1'b1;
      case (w_buf)
         G_LOW:   w_sym = 3'd1;
         G_MED:   w_sym = 3'd2;
         G_HIGH:  w_sym = 3'd3;
         G_ERR:   w_sym = 3'd4;
         G_A:     w_sym = 3'd5;
         G_G:     w_sym = 3'd6;
         G_ZERO:  w_sym = 3'd7;
         default: w_match = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int i = 0; i < 5; i++)
            r_buf[i] <= '0;
         r_exp   <= '0;
         r_tmo   <= '0;
         r_sym   <= '0;
         r_match <= 1'b0;
         r_frame <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_valid_n;
         r_err   <= w_err_n;
         r_exp   <= w_exp_n;
         if (w_wr)
            r_buf[w_idx] <= w_rows;
         if (w_tmo_clr)
            r_tmo <= '0;
         else if (r_state == S_CAPT)
            r_tmo <= r_tmo + 1'b1;
         if (w_decode) begin
            r_frame <= w_buf;
            r_sym   <= w_sym;
            r_match <= w_match;
         end
      end
   end

   assign sym       = r_sym;
   assign match     = r_match;
   assign frame     = r_frame;
   assign sym_valid = r_valid;
   assign seq_err   = r_err;

endmodule

// File: tb/tb_led_matrix_scan_decoder.sv
// Directed bench for led_matrix_scan_decoder: glyph vector table
// plus hand-written sequence, restart, timing, timeout and reset cases.
module tb_led_matrix_scan_decoder;

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  col;
   logic [6:0]  lin;
   logic [2:0]  sym;
   logic        sym_valid;
   logic        match;
   logic [34:0] frame;
   logic        seq_err;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_err   = 0;
   int n_both  = 0;

   typedef struct {
      logic [34:0] pat;
      logic [2:0]  sym;
      logic        mt;
   } vec_t;

   vec_t tv [8];

   always #5 clk = ~clk;

   led_matrix_scan_decoder #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (2),
      .TIMEOUT       (16)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .col       (col),
      .lin       (lin),
      .sym       (sym),
      .sym_valid (sym_valid),
      .match     (match),
      .frame     (frame),
      .seq_err   (seq_err),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (sym_valid === 1'b1) n_valid++;
      if (seq_err === 1'b1) n_err++;
      if (sym_valid === 1'b1 && seq_err === 1'b1) n_both++;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic hold(input logic [4:0] c, input logic [6:0] l,
                       input int n);
      col = c;
      lin = l;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [34:0] p);
      for (int c = 0; c < 5; c++)
         hold(5'(1 << c), p[7*c +: 7], 8);
      hold(5'd0, 7'd0, 24);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      int e0;
      logic [4:0] sv;
      logic [20:1] se;
      logic b18;

      tv[0] = '{pat: {5{7'h3F}}, sym: 3'd1, mt: 1'b1};
      tv[1] = '{pat: {5{7'h37}}, sym: 3'd2, mt: 1'b1};
      tv[2] = '{pat: {5{7'h36}}, sym: 3'd3, mt: 1'b1};
      tv[3] = '{pat: {7'h3E, 7'h36, 7'h36, 7'h36, 7'h00},
                sym: 3'd4, mt: 1'b1};
      tv[4] = '{pat: {7'h00, 7'h6E, 7'h6E, 7'h6E, 7'h00},
                sym: 3'd5, mt: 1'b1};
      tv[5] = '{pat: {7'h06, 7'h36, 7'h3E, 7'h3E, 7'h00},
                sym: 3'd6, mt: 1'b1};
      tv[6] = '{pat: {7'h00, 7'h3E, 7'h3E, 7'h3E, 7'h00},
                sym: 3'd7, mt: 1'b1};
      tv[7] = '{pat: {5{7'h01}}, sym: 3'd0, mt: 1'b0};

      col  = '0;
      lin  = '0;
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst sym", 64'(sym), 0);
      chk("rst valid", 64'(sym_valid), 0);
      chk("rst match", 64'(match), 0);
      chk("rst frame", 64'(frame), 0);
      chk("rst err", 64'(seq_err), 0);
      chk("rst busy", 64'(busy), 0);

      // glyph table
      for (int i = 0; i < 8; i++) begin
         v0 = n_valid;
         e0 = n_err;
         send(tv[i].pat);
         chk($sformatf("v%0d pulses", i), 64'(n_valid - v0), 1);
         chk($sformatf("v%0d errs", i), 64'(n_err - e0), 0);
         chk($sformatf("v%0d sym", i), 64'(sym), 64'(tv[i].sym));
         chk($sformatf("v%0d match", i), 64'(match), 64'(tv[i].mt));
         chk($sformatf("v%0d frame", i), 64'(frame), 64'(tv[i].pat));
      end

      // out of order col_1, col_2, col_4
      v0 = n_valid;
      e0 = n_err;
      hold(5'b00001, 7'h3E, 8);
      hold(5'b00010, 7'h3E, 8);
      hold(5'b01000, 7'h3E, 8);
      hold(5'd0, 7'd0, 24);
      chk("ooo errs", 64'(n_err - e0), 1);
      chk("ooo pulses", 64'(n_valid - v0), 0);
      chk("ooo busy", 64'(busy), 0);
      v0 = n_valid;
      send(tv[6].pat);
      chk("ooo zero pulses", 64'(n_valid - v0), 1);
      chk("ooo zero sym", 64'(sym), 7);

      // mid-frame restart then MED
      v0 = n_valid;
      e0 = n_err;
      hold(5'b00001, 7'h37, 8);
      hold(5'b00010, 7'h37, 8);
      send(tv[1].pat);
      chk("rs errs", 64'(n_err - e0), 1);
      chk("rs pulses", 64'(n_valid - v0), 1);
      chk("rs sym", 64'(sym), 2);

      // multi-hot column
      v0 = n_valid;
      e0 = n_err;
      hold(5'b00001, 7'h3F, 8);
      chk("mh busy pre", 64'(busy), 1);
      hold(5'b00011, 7'h3F, 8);
      chk("mh errs", 64'(n_err - e0), 1);
      chk("mh busy", 64'(busy), 0);
      hold(5'd0, 7'd0, 24);
      chk("mh pulses", 64'(n_valid - v0), 0);

      // stability: 1-clk col_5 ignored, 2-clk col_5 decoded on edge 4
      v0 = n_valid;
      e0 = n_err;
      hold(5'b00001, 7'h3F, 8);
      hold(5'b00010, 7'h3F, 8);
      hold(5'b00100, 7'h3F, 8);
      hold(5'b01000, 7'h3F, 8);
      hold(5'b10000, 7'h3F, 1);
      hold(5'd0, 7'd0, 4);
      chk("st short pulses", 64'(n_valid - v0), 0);
      chk("st short busy", 64'(busy), 1);
      col = 5'b10000;
      lin = 7'h3F;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         sv[k] = sym_valid;
         if (k == 2) begin
            col = '0;
            lin = '0;
         end
      end
      chk("st latency", 64'(sv[4:1]), 64'(4'b1000));
      @(negedge clk);
      hold(5'd0, 7'd0, 24);
      chk("st sym", 64'(sym), 1);
      chk("st pulses", 64'(n_valid - v0), 1);
      chk("st errs", 64'(n_err - e0), 0);

      // timeout 16 edges after col_3 capture
      hold(5'b00001, 7'h3F, 8);
      hold(5'b00010, 7'h3F, 8);
      col = 5'b00100;
      b18 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         se[k] = seq_err;
         if (k == 18) b18 = busy;
         if (k == 8) col = '0;
      end
      chk("tmo early", 64'(se[18:1]), 0);
      chk("tmo busy", 64'(b18), 1);
      chk("tmo hit", 64'(se[19]), 1);
      chk("tmo pulse", 64'(se[20]), 0);
      chk("tmo hunt", 64'(busy), 0);
      @(negedge clk);
      hold(5'd0, 7'd0, 8);

      // reset mid-frame then HIGH
      hold(5'b00001, 7'h36, 8);
      hold(5'b00010, 7'h36, 8);
      hold(5'b00100, 7'h36, 8);
      chk("mr busy pre", 64'(busy), 1);
      rstn = 1'b1;
      @(negedge clk);
      chk("mr sym", 64'(sym), 0);
      chk("mr match", 64'(match), 0);
      chk("mr frame", 64'(frame), 0);
      chk("mr busy", 64'(busy), 0);
      chk("mr valid", 64'(sym_valid), 0);
      rstn = 1'b0;
      hold(5'd0, 7'd0, 8);
      v0 = n_valid;
      send(tv[2].pat);
      chk("mr high pulses", 64'(n_valid - v0), 1);
      chk("mr high sym", 64'(sym), 3);

      chk("valid+err overlap", 64'(n_both), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
